reorder_buffer_commit_unit: RTL
===============================

Name: reorder_buffer_commit_unit

Overview:
Retire-side controller for the reorder buffer; the consumer end of the entry stream that the allocate side fills.
- Inspects the two oldest entries each cycle and commits 0, 1 or 2 of them in order.
- Writes committed results to the register file and drives the shift/shift-2 strobes into the ROB occupancy counter.
- Owns the head pointer and the exception-flush sequence.

Parameters:
TAG_BITS_SIZE, 4, ROB index/occupancy width; depth = 2**TAG_BITS_SIZE entries
DATA_WIDTH, 32, result data width
REG_ADDR_WIDTH, 4, architectural destination register index width

Ports:
clk_in  input  1  clock, rising edge
reset_in  input  1  synchronous, active-high reset
reorder_buffer_status_in  input  TAG_BITS_SIZE  current occupancy from the ROB counter
commit_stall_in  input  1  register file cannot accept writes this cycle
head0_ready_in  input  1  entry at head has completed
head0_exc_in  input  1  entry at head raised an exception
head0_dest_in  input  REG_ADDR_WIDTH  head entry destination register
head0_data_in  input  DATA_WIDTH  head entry result
head1_ready_in, head1_exc_in, head1_dest_in, head1_data_in  input  1/1/REG_ADDR_WIDTH/DATA_WIDTH  same fields for entry head+1
reorder_buffer_shift_out  output  1  retire one entry this cycle (combinational)
reorder_buffer_shift_2_out  output  1  retire two entries this cycle (combinational)
head_ptr_out  output  TAG_BITS_SIZE  index of current head entry (registered)
rf_we0_out, rf_we1_out  output  1  register file write enables (registered)
rf_addr0_out, rf_addr1_out  output  REG_ADDR_WIDTH  write addresses (registered)
rf_data0_out, rf_data1_out  output  DATA_WIDTH  write data (registered)
flush_out  output  1  one-cycle pipeline flush pulse (registered)
exc_tag_out  output  TAG_BITS_SIZE  head index of the faulting entry, valid with flush_out

Behaviour:
- Reset, synchronous on reset_in high at the clock edge:
  - State RUN; head_ptr_out=0.
  - All rf_we*, flush_out = 0; rf_addr*, rf_data*, exc_tag_out = 0.
  - Shift outputs are forced 0 while reset_in is high.
  - Reset mid-flush abandons the flush.
- Commit decision: combinational, Mealy, evaluated in RUN only. Let ok0 = head0_ready & ~head0_exc, and ok1 = head1_ready & ~head1_exc.
  - commit_stall_in=1: no shift; stay in RUN.
  - status>=2 & ok0 & ok1: shift_2_out=1.
  - else status>=1 & ok0: shift_out=1.
  - else status>=1 & head0_ready & head0_exc: no shift; next state FLUSH.
  - A head1 exception is never acted on while head0 is committing. Head0 commits alone; the exception is taken next cycle when that entry is at head.
  - head0/head1 fields are ignored when status is below 1/2 respectively.
  - shift_out and shift_2_out are never both 1. The counter holds on that encoding, and the bench asserts it never occurs.
- Head pointer:
  - Advances by 1 on shift and by 2 on shift_2.
  - Arithmetic is modulo 2**TAG_BITS_SIZE, wrapping 15 to 0 and 15+2 to 1.
  - Updates on the same edge the counter consumes the strobe.
- Writeback: 1-cycle latency after the commit decision.
  - shift: we0=1 with head0 dest/data; we1=0.
  - shift_2: we0 from head0, we1 from head1.
  - If both write the same address, port 1 is younger and the register file gives port 1 priority; this block passes both through.
  - Enables are 0 in every non-commit cycle.
- FSM:
  - RUN: transitions as in the commit decision.
  - FLUSH: one cycle. flush_out=1 and exc_tag_out=head_ptr. No shifts; then WAIT_EMPTY.
  - WAIT_EMPTY: no shifts and no writes. When status_in==0, return to RUN and set head_ptr_out=0, realigning with the allocator, which the flush also resets.
- Status of 0: never shift, whatever the head flags say.
- Entry ordering is strictly in-order; no entry commits past an older incomplete one.

Decomposition:
- Shared package/define file: TAG_BITS_SIZE, FSM state encodings (RUN, FLUSH, WAIT_EMPTY, 2 bits), and the ROB entry field widths, shared with the allocate side and the counter.
- One sub-module is natural: reorder_buffer_commit_select.
  - Purely combinational: ok0/ok1, status, stall in; shift/shift_2/take-exception out.
- The FSM, head pointer and writeback registers stay in the top module.

Test Plan:
- Reset then idle, status=0 with both ready flags 1 -> no shift, head_ptr=0, all we=0, flush_out=0.
- status=3, head0/head1 ready, no exc, dest 2/5, data 0xA/0xB -> shift_2=1 that cycle. Next cycle we0/we1=1 with addr 2/5 and data 0xA/0xB; head_ptr=2.
- status=1, head0 ready, head1 ready -> shift=1 only (head1 ignored); next cycle we0=1, we1=0; head_ptr+1.
- head_ptr=15, status=4, both ok -> shift_2 -> head_ptr=1; head_ptr=15 with single shift -> 0.
- head0 ready+exc at head_ptr=6 -> no shift, next cycle flush_out=1 for one cycle with exc_tag_out=6. No shifts while status>0; head_ptr=0 and RUN once status=0.
- commit_stall_in=1 with both entries ok -> no shift/no write. Reset asserted during WAIT_EMPTY -> RUN, head_ptr=0. Over all cycles, shift & shift_2 never both 1.

Source files
------------

// File: rtl/reorder_buffer_commit_unit_pkg.sv
// Shared ROB definitions: default widths and the commit-side FSM encoding,
// common to the allocate side, the occupancy counter and the commit unit.
package reorder_buffer_commit_unit_pkg;

  localparam int ROB_TAG_BITS       = 4;
  localparam int ROB_DATA_WIDTH     = 32;
  localparam int ROB_REG_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FLUSH      = 2'd1,
    ST_WAIT_EMPTY = 2'd2
  } commit_state_t;

  // An entry may retire only once it has completed without faulting.
  function automatic logic entry_ok(input logic ready, input logic exc);
    return ready & ~exc;
  endfunction

endpackage

// File: rtl/reorder_buffer_commit_unit_select.sv
// Combinational retire decision for the two oldest ROB entries.
// Commits strictly in order; an exception is taken only from the head entry.
module reorder_buffer_commit_select
  import reorder_buffer_commit_unit_pkg::*;
#(
  parameter int TAG_BITS_SIZE = ROB_TAG_BITS
) (
  input  logic                     run,
  input  logic                     stall,
  input  logic                     ok0,
  input  logic                     ok1,
  input  logic                     exc0,
  input  logic [TAG_BITS_SIZE-1:0] status,
  output logic                     shift,
  output logic                     shift_2,
  output logic                     take_exc
);

  localparam logic [TAG_BITS_SIZE-1:0] ONE = TAG_BITS_SIZE'(1);
  localparam logic [TAG_BITS_SIZE-1:0] TWO = TAG_BITS_SIZE'(2);

  always_comb begin
    shift    = 1'b0;
    shift_2  = 1'b0;
    take_exc = 1'b0;
    if (run && !stall) begin
      if (status >= TWO && ok0 && ok1) begin
        shift_2 = 1'b1;
      end else if (status >= ONE && ok0) begin
        // A faulting head1 waits here until it becomes the head entry.
        shift = 1'b1;
      end else if (status >= ONE && exc0) begin
        take_exc = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_commit_unit.sv
// ROB retire controller: in-order commit of up to two entries, register file
// writeback one cycle later, head pointer ownership and the exception flush.
module reorder_buffer_commit_unit
  import reorder_buffer_commit_unit_pkg::*;
#(
  parameter int TAG_BITS_SIZE  = ROB_TAG_BITS,
  parameter int DATA_WIDTH     = ROB_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = ROB_REG_ADDR_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic [TAG_BITS_SIZE-1:0]  reorder_buffer_status_in,
  input  logic                      commit_stall_in,
  input  logic                      head0_ready_in,
  input  logic                      head0_exc_in,
  input  logic [REG_ADDR_WIDTH-1:0] head0_dest_in,
  input  logic [DATA_WIDTH-1:0]     head0_data_in,
  input  logic                      head1_ready_in,
  input  logic                      head1_exc_in,
  input  logic [REG_ADDR_WIDTH-1:0] head1_dest_in,
  input  logic [DATA_WIDTH-1:0]     head1_data_in,
  output logic                      reorder_buffer_shift_out,
  output logic                      reorder_buffer_shift_2_out,
  output logic [TAG_BITS_SIZE-1:0]  head_ptr_out,
  output logic                      rf_we0_out,
  output logic                      rf_we1_out,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr0_out,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr1_out,
  output logic [DATA_WIDTH-1:0]     rf_data0_out,
  output logic [DATA_WIDTH-1:0]     rf_data1_out,
  output logic                      flush_out,
  output logic [TAG_BITS_SIZE-1:0]  exc_tag_out
);

  localparam logic [TAG_BITS_SIZE-1:0] ONE = TAG_BITS_SIZE'(1);
  localparam logic [TAG_BITS_SIZE-1:0] TWO = TAG_BITS_SIZE'(2);

  commit_state_t state;
  logic          run;
  logic          shift;
  logic          shift_2;
  logic          take_exc;

  // Strobes feed the occupancy counter directly, so reset must mask them.
  assign run = (state == ST_RUN) && !reset_in;

  reorder_buffer_commit_select #(
    .TAG_BITS_SIZE (TAG_BITS_SIZE)
  ) u_select (
    .run      (run),
    .stall    (commit_stall_in),
    .ok0      (entry_ok(head0_ready_in, head0_exc_in)),
    .ok1      (entry_ok(head1_ready_in, head1_exc_in)),
    .exc0     (head0_ready_in & head0_exc_in),
    .status   (reorder_buffer_status_in),
    .shift    (shift),
    .shift_2  (shift_2),
    .take_exc (take_exc)
  );

  assign reorder_buffer_shift_out   = shift;
  assign reorder_buffer_shift_2_out = shift_2;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state        <= ST_RUN;
      head_ptr_out <= '0;
      rf_we0_out   <= 1'b0;
      rf_we1_out   <= 1'b0;
      rf_addr0_out <= '0;
      rf_addr1_out <= '0;
      rf_data0_out <= '0;
      rf_data1_out <= '0;
      flush_out    <= 1'b0;
      exc_tag_out  <= '0;
    end else begin
      rf_we0_out <= shift | shift_2;
      rf_we1_out <= shift_2;
      flush_out  <= 1'b0;
      if (shift || shift_2) begin
        rf_addr0_out <= head0_dest_in;
        rf_data0_out <= head0_data_in;
      end
      if (shift_2) begin
        rf_addr1_out <= head1_dest_in;
        rf_data1_out <= head1_data_in;
      end
      if (shift) begin
        head_ptr_out <= head_ptr_out + ONE;
      end else if (shift_2) begin
        head_ptr_out <= head_ptr_out + TWO;
      end

      case (state)
        ST_RUN: begin
          if (take_exc) begin
            state       <= ST_FLUSH;
            flush_out   <= 1'b1;
            exc_tag_out <= head_ptr_out;
          end
        end
        ST_FLUSH: begin
          state <= ST_WAIT_EMPTY;
        end
        ST_WAIT_EMPTY: begin
          // The allocator restarts at index 0 after a flush; follow it.
          if (reorder_buffer_status_in == '0) begin
            state        <= ST_RUN;
            head_ptr_out <= '0;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule
